brick_field_ctrl: RTL and testbench

- Parametrised brick-wall manager for the breakout graphics path; the successor to the fixed single-row brick logic.
- Holds a ROWS×COLS alive/destroyed map and renders bricks for the current pixel, with a per-row colour.
- On each refresh tick it scans the bricks sequentially against a snapshot of the ball and destroys at most one brick.
- Reports the struck side so the ball logic can reflect velocity; also maintains a remaining-brick count and an all-clear flag.

---
 rtl/brick_field_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_brick_field_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/brick_field_ctrl.sv
// Brick-wall manager for the breakout graphics path.
// Keeps a ROWS x COLS alive map, renders live bricks for the current pixel
// with a per-row colour, and on each check scans the bricks one per clock
// against a snapshot of the ball, destroying at most one brick per scan.
module brick_field_ctrl #(
  parameter int ROWS       = 6,
  parameter int COLS       = 8,
  parameter int BRICK_W    = 35,
  parameter int BRICK_H    = 20,
  parameter int REGION_X_L = 40,
  parameter int REGION_Y_T = 30,
  parameter int BALL_SIZE  = 8,
  localparam int N         = ROWS * COLS,
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1,
  localparam int CNT_W     = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             check,
  input  logic [9:0]       ball_x_l,
  input  logic [9:0]       ball_y_t,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  output logic             brick_on,
  output logic [11:0]      brick_rgb,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [1:0]       hit_side,
  output logic [IDX_W-1:0] hit_idx,
  output logic [CNT_W-1:0] bricks_left,
  output logic             all_clear
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t           state;
  logic [N-1:0]     alive;
  logic [IDX_W-1:0] idx;
  logic [2:0]       scan_row;
  logic [3:0]       scan_col;
  logic [9:0]       snap_x;
  logic [9:0]       snap_y;

  // Geometry is evaluated in 11 bits so edge sums never wrap.
  function automatic logic [10:0] col_left(input int c);
    return 11'(REGION_X_L + c * BRICK_W);
  endfunction

  function automatic logic [10:0] row_top(input int r);
    return 11'(REGION_Y_T + r * BRICK_H);
  endfunction

  function automatic logic [11:0] row_colour(input int r);
    logic [2:0] sel;
    sel = 3'(r);
    case (sel)
      3'd0:    return 12'hf00;
      3'd1:    return 12'hf80;
      3'd2:    return 12'hff0;
      3'd3:    return 12'h0f0;
      3'd4:    return 12'h0ff;
      3'd5:    return 12'h00f;
      3'd6:    return 12'hf0f;
      default: return 12'hfff;
    endcase
  endfunction

  // Pixel path: find the live brick (if any) under the current pixel.
  always_comb begin
    brick_on  = 1'b0;
    brick_rgb = 12'h000;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (alive[r*COLS + c] &&
            ({1'b0, pix_x} >= col_left(c)) &&
            ({1'b0, pix_x} <= col_left(c) + 11'(BRICK_W - 2)) &&
            ({1'b0, pix_y} >= row_top(r)) &&
            ({1'b0, pix_y} <= row_top(r) + 11'(BRICK_H - 2))) begin
          brick_on  = 1'b1;
          brick_rgb = row_colour(r);
        end
      end
    end
  end

  logic [10:0] cur_left, cur_right, cur_top, cur_bot;
  logic [10:0] bx_l, bx_r, by_t, by_b;
  logic [10:0] ov_x_hi, ov_x_lo, ov_y_hi, ov_y_lo, ox, oy;
  logic        overlap;
  logic [1:0]  side;

  // Overlap and struck-side evaluation of the brick currently being scanned.
  always_comb begin
    cur_left  = 11'(REGION_X_L) + 11'(scan_col) * 11'(BRICK_W);
    cur_top   = 11'(REGION_Y_T) + 11'(scan_row) * 11'(BRICK_H);
    cur_right = cur_left + 11'(BRICK_W - 2);
    cur_bot   = cur_top + 11'(BRICK_H - 2);
    bx_l      = {1'b0, snap_x};
    by_t      = {1'b0, snap_y};
    bx_r      = bx_l + 11'(BALL_SIZE - 1);
    by_b      = by_t + 11'(BALL_SIZE - 1);
    overlap   = alive[idx] && (cur_left <= bx_r) && (bx_l <= cur_right) &&
                (cur_top <= by_b) && (by_t <= cur_bot);
    ov_x_hi   = (bx_r < cur_right) ? bx_r : cur_right;
    ov_x_lo   = (bx_l > cur_left) ? bx_l : cur_left;
    ov_y_hi   = (by_b < cur_bot) ? by_b : cur_bot;
    ov_y_lo   = (by_t > cur_top) ? by_t : cur_top;
    ox        = ov_x_hi - ov_x_lo + 11'd1;
    oy        = ov_y_hi - ov_y_lo + 11'd1;
    if (ox < oy) begin
      side = (bx_l + 11'(BALL_SIZE / 2) < cur_left + 11'((BRICK_W - 1) / 2)) ? 2'd0 : 2'd1;
    end else begin
      side = (by_t + 11'(BALL_SIZE / 2) < cur_top + 11'((BRICK_H - 1) / 2)) ? 2'd2 : 2'd3;
    end
  end

  // Scan FSM with registered status outputs; clear restores the wall and aborts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      alive       <= '1;
      bricks_left <= CNT_W'(N);
      busy        <= 1'b0;
      done        <= 1'b0;
      hit         <= 1'b0;
      all_clear   <= 1'b0;
      hit_side    <= 2'd0;
      hit_idx     <= '0;
      idx         <= '0;
      scan_row    <= '0;
      scan_col    <= '0;
      snap_x      <= '0;
      snap_y      <= '0;
    end else if (clear) begin
      state       <= IDLE;
      alive       <= '1;
      bricks_left <= CNT_W'(N);
      busy        <= 1'b0;
      done        <= 1'b0;
      hit         <= 1'b0;
      all_clear   <= 1'b0;
    end else begin
      all_clear <= (bricks_left == '0);
      done      <= 1'b0;
      hit       <= 1'b0;
      case (state)
        IDLE: begin
          if (check) begin
            snap_x   <= ball_x_l;
            snap_y   <= ball_y_t;
            idx      <= '0;
            scan_row <= '0;
            scan_col <= '0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (overlap) begin
            alive[idx]  <= 1'b0;
            bricks_left <= bricks_left - CNT_W'(1);
            hit_side    <= side;
            hit_idx     <= idx;
            hit         <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= REPORT;
          end else if (idx == IDX_W'(N - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= REPORT;
          end else begin
            idx <= idx + IDX_W'(1);
            if (scan_col == 4'(COLS - 1)) begin
              scan_col <= '0;
              scan_row <= scan_row + 3'd1;
            end else begin
              scan_col <= scan_col + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brick_field_ctrl.sv
// Self-checking bench for brick_field_ctrl: directed steps with a scoreboard
// of expected scan results built from an independent model of the wall.
module tb_brick_field_ctrl;

  localparam int ROWS = 6;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;
  localparam int BW   = 35;
  localparam int BH   = 20;
  localparam int XL   = 40;
  localparam int YT   = 30;
  localparam int BS   = 8;

  logic        clk = 1'b0;
  logic        reset, clear, check;
  logic [9:0]  ball_x_l, ball_y_t, pix_x, pix_y;
  logic        brick_on;
  logic [11:0] brick_rgb;
  logic        busy, done, hit;
  logic [1:0]  hit_side;
  logic [5:0]  hit_idx;
  logic [5:0]  bricks_left;
  logic        all_clear;

  brick_field_ctrl dut (
    .clk(clk), .reset(reset), .clear(clear), .check(check),
    .ball_x_l(ball_x_l), .ball_y_t(ball_y_t), .pix_x(pix_x), .pix_y(pix_y),
    .brick_on(brick_on), .brick_rgb(brick_rgb), .busy(busy), .done(done),
    .hit(hit), .hit_side(hit_side), .hit_idx(hit_idx),
    .bricks_left(bricks_left), .all_clear(all_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit hit;
    int side;
    int idx;
    int lat;
  } exp_t;

  exp_t sb[$];
  bit   model_alive[N];
  int   model_left;
  int   compared   = 0;
  int   mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      $error("[TB] %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) model_alive[i] = 1'b1;
    model_left = N;
  endtask

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Reference scan: first live overlapping brick wins and is destroyed.
  task automatic modelScan(input int x, input int y, output exp_t e);
    int l, r, t, b, xr, yb, ox, oy;
    e.hit = 1'b0; e.side = 0; e.idx = 0; e.lat = N;
    xr = x + BS - 1;
    yb = y + BS - 1;
    for (int i = 0; i < N; i++) begin
      l = XL + (i % COLS) * BW;  r = l + BW - 2;
      t = YT + (i / COLS) * BH;  b = t + BH - 2;
      if (model_alive[i] && l <= xr && x <= r && t <= yb && y <= b) begin
        ox = imin(xr, r) - imax(x, l) + 1;
        oy = imin(yb, b) - imax(y, t) + 1;
        if (ox < oy) e.side = (x + BS/2 < l + (BW-1)/2) ? 0 : 1;
        else         e.side = (y + BS/2 < t + (BH-1)/2) ? 2 : 3;
        e.hit = 1'b1;
        e.idx = i;
        e.lat = i + 1;
        model_alive[i] = 1'b0;
        model_left--;
        break;
      end
    end
  endtask

  // Issue one check, queue the expectation, then wait for done and compare.
  task automatic applyStimulus(input int x, input int y);
    exp_t e;
    int   lat;
    bit   got;
    @(negedge clk);
    ball_x_l = 10'(x);
    ball_y_t = 10'(y);
    check    = 1'b1;
    modelScan(x, y, e);
    sb.push_back(e);
    @(negedge clk);
    check = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) got = 1'b1;
    end
    e = sb.pop_front();
    checkOutput("done_seen", 32'(got), 32'd1);
    if (got) begin
      checkOutput("latency", 32'(lat), 32'(e.lat));
      checkOutput("hit", 32'(hit), 32'(e.hit));
      if (e.hit) begin
        checkOutput("hit_side", 32'(hit_side), 32'(e.side));
        checkOutput("hit_idx", 32'(hit_idx), 32'(e.idx));
      end
      checkOutput("bricks_left", 32'(bricks_left), 32'(model_left));
    end
  endtask

  task automatic checkPixel(input string tag, input int x, input int y,
                            input logic on_exp, input logic [11:0] rgb_exp);
    @(negedge clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
    #1;
    checkOutput({tag, "_on"}, 32'(brick_on), 32'(on_exp));
    checkOutput({tag, "_rgb"}, 32'(brick_rgb), 32'(rgb_exp));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_hit"}, 32'(hit), 32'd0);
    checkOutput({tag, "_side"}, 32'(hit_side), 32'd0);
    checkOutput({tag, "_idx"}, 32'(hit_idx), 32'd0);
    checkOutput({tag, "_left"}, 32'(bricks_left), 32'(N));
    checkOutput({tag, "_allclr"}, 32'(all_clear), 32'd0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; clear = 1'b0; check = 1'b0;
    ball_x_l = '0; ball_y_t = '0; pix_x = '0; pix_y = '0;
    modelReset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] step 1: reset state and pixel path");
    checkResetState("rst");
    checkPixel("pix_b0", 40, 30, 1'b1, 12'hf00);
    checkPixel("pix_gap", 74, 30, 1'b0, 12'h000);
    checkPixel("pix_row1", 40, 50, 1'b1, 12'hf80);
    checkPixel("pix_last", 40 + 7*BW + 33, 30 + 5*BH + 18, 1'b1, 12'h00f);

    $display("[TB] step 2: left-side hit on brick 0");
    applyStimulus(36, 36);
    checkPixel("pix_b0_gone", 40, 30, 1'b0, 12'h000);

    $display("[TB] step 3: repeat check, no live overlap");
    applyStimulus(36, 36);

    $display("[TB] step 4: two candidates, lowest index wins");
    applyStimulus(80, 64);
    checkPixel("pix_b9_gone", 75, 50, 1'b0, 12'h000);
    checkPixel("pix_b17_alive", 75, 70, 1'b1, 12'hff0);

    $display("[TB] step 5: clear aborts a scan, coincident check ignored");
    @(negedge clk);
    ball_x_l = 10'd600; ball_y_t = 10'd400; check = 1'b1;
    @(negedge clk);
    check = 1'b0;
    checkOutput("scan_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1; check = 1'b1;
    @(negedge clk);
    clear = 1'b0; check = 1'b0;
    modelReset();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_left", 32'(bricks_left), 32'(N));
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checkOutput("abort_quiet", 32'(seen), 32'd0);
    checkPixel("pix_b0_restored", 40, 30, 1'b1, 12'hf00);

    $display("[TB] step 6: destroy the whole wall");
    for (int i = 0; i < N; i++) begin
      applyStimulus(XL + (i % COLS) * BW + 10, YT + (i / COLS) * BH + 5);
    end
    checkOutput("allclr_lag", 32'(all_clear), 32'd0);
    @(negedge clk);
    checkOutput("allclr_set", 32'(all_clear), 32'd1);
    applyStimulus(XL + 10, YT + 5);
    checkOutput("allclr_hold", 32'(all_clear), 32'd1);

    $display("[TB] step 6b: reset in the middle of a scan");
    @(negedge clk);
    ball_x_l = 10'd600; ball_y_t = 10'd400; check = 1'b1;
    @(negedge clk);
    check = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkResetState("midrst");
    checkPixel("pix_after_rst", 40, 30, 1'b1, 12'hf00);
    applyStimulus(36, 36);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
